// File: rtl/gcd_stream.sv
// Streaming binary (Stein) GCD engine with valid/ready handshakes on both sides.
// One operand pair is in flight at a time; the result is held until the consumer
// takes it, and a new pair is accepted only from IDLE.
module gcd_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd,
    output logic             busy
);

    // k counts common factors of two; it never reaches WIDTH for nonzero operands.
    localparam int unsigned KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StSub,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_result;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] w_x_next;
    logic [WIDTH-1:0] w_y_next;
    logic [WIDTH-1:0] w_result_next;
    logic [KW-1:0]    w_k_next;

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_x      <= '0;
            r_y      <= '0;
            r_k      <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_k      <= w_k_next;
            r_result <= w_result_next;
        end
    end

    // Next-state and datapath update: one Stein step per cycle.
    always_comb begin
        w_state_next  = r_state;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_k_next      = r_k;
        w_result_next = r_result;
        case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_x_next = a;
                    w_y_next = b;
                    w_k_next = '0;
                    if ((a == '0) || (b == '0)) begin
                        // gcd(n,0)=n and gcd(0,0)=0 both reduce to a|b.
                        w_result_next = a | b;
                        w_state_next  = StDone;
                    end else begin
                        w_state_next = StShift;
                    end
                end
            end
            StShift: begin
                if (!r_x[0] && !r_y[0]) begin
                    w_x_next = r_x >> 1;
                    w_y_next = r_y >> 1;
                    w_k_next = r_k + 1'b1;
                end else begin
                    w_state_next = StSub;
                end
            end
            StSub: begin
                if (!r_x[0]) begin
                    w_x_next = r_x >> 1;
                end else if (!r_y[0]) begin
                    w_y_next = r_y >> 1;
                end else if (r_x == r_y) begin
                    w_result_next = r_x << r_k;
                    w_state_next  = StDone;
                end else if (r_x > r_y) begin
                    w_x_next = r_x - r_y;
                end else begin
                    w_y_next = r_y - r_x;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Handshake and status outputs decoded from state; gcd keeps the last result.
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
        busy      = (r_state == StShift) || (r_state == StSub);
        gcd       = r_result;
    end

endmodule

// File: tb/tb_gcd_stream.sv
// Self-checking bench for gcd_stream: directed table, random pairs against a
// Euclid reference, plus backpressure and mid-operation reset sequences.
module tb_gcd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] drv_a;
    logic [15:0] drv_b;
    logic        iv8;
    logic        iv16;
    logic        out_ready;
    logic        wide;

    logic        ir8, ov8, busy8;
    logic [7:0]  g8;
    logic        ir16, ov16, busy16;
    logic [15:0] g16;

    logic        ir, ov, bsy;
    logic [15:0] g;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gcd_stream #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (drv_a[7:0]),
        .b         (drv_b[7:0]),
        .out_valid (ov8),
        .out_ready (out_ready),
        .gcd       (g8),
        .busy      (busy8)
    );

    gcd_stream #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (drv_a),
        .b         (drv_b),
        .out_valid (ov16),
        .out_ready (out_ready),
        .gcd       (g16),
        .busy      (busy16)
    );

    assign ir  = wide ? ir16 : ir8;
    assign ov  = wide ? ov16 : ov8;
    assign bsy = wide ? busy16 : busy8;
    assign g   = wide ? g16 : {8'h00, g8};

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        int          max_lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] x_in, input logic [15:0] y_in);
        logic [15:0] x, y, t;
        x = x_in;
        y = y_in;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Wait for out_valid with a cycle budget; returns edges counted since accept.
    task automatic wait_result(input int limit, output int cycles, output bit got,
                               output bit busy_seen);
        cycles    = 0;
        got       = 1'b0;
        busy_seen = 1'b0;
        while (!got && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (bsy) busy_seen = 1'b1;
            if (ov) got = 1'b1;
        end
    endtask

    task automatic run_pair(input logic w, input logic [15:0] av, input logic [15:0] bv,
                            input logic [15:0] exp, input int max_lat, input string name);
        int cycles;
        bit got, busy_seen;
        wide = w;
        @(negedge clk);
        drv_a = av;
        drv_b = bv;
        if (w) iv16 = 1'b1; else iv8 = 1'b1;
        check({name, " in_ready"}, ir, 1);
        @(posedge clk);
        #1;
        iv8   = 1'b0;
        iv16  = 1'b0;
        // Operands must have been sampled at accept only.
        drv_a = ~av;
        drv_b = ~bv;
        wait_result(max_lat + 4, cycles, got, busy_seen);
        check({name, " out_valid"}, got, 1);
        check({name, " gcd"}, g, exp);
        check({name, " latency_ok"}, (cycles <= max_lat), 1);
        if (av == 0 || bv == 0) begin
            check({name, " zero_latency"}, cycles, 1);
            check({name, " busy_seen"}, busy_seen, 0);
        end else begin
            check({name, " busy_seen"}, busy_seen, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, " consumed"}, ov, 0);
        check({name, " idle_ready"}, ir, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          cycles;
        bit          got, busy_seen;
        logic [15:0] ra, rb;

        tbl[0] = '{1'b0, 16'd48,    16'd18,    16'd6,    36};
        tbl[1] = '{1'b0, 16'd0,     16'd0,     16'd0,    36};
        tbl[2] = '{1'b0, 16'd0,     16'd37,    16'd37,   36};
        tbl[3] = '{1'b0, 16'd200,   16'd0,     16'd200,  36};
        tbl[4] = '{1'b0, 16'd233,   16'd144,   16'd1,    36};
        tbl[5] = '{1'b0, 16'd255,   16'd255,   16'd255,  36};
        tbl[6] = '{1'b0, 16'd128,   16'd64,    16'd64,   36};
        tbl[7] = '{1'b1, 16'd65535, 16'd4369,  16'd4369, 68};
        tbl[8] = '{1'b1, 16'd40960, 16'd12288, 16'd4096, 68};
        tbl[9] = '{1'b1, 16'd0,     16'd513,   16'd513,  68};

        rst       = 1'b1;
        iv8       = 1'b0;
        iv16      = 1'b0;
        out_ready = 1'b0;
        drv_a     = '0;
        drv_b     = '0;
        wide      = 1'b0;

        #12;
        check("rst in_ready8", ir8, 1);
        check("rst out_valid8", ov8, 0);
        check("rst gcd8", g8, 0);
        check("rst busy8", busy8, 0);
        check("rst in_ready16", ir16, 1);
        check("rst out_valid16", ov16, 0);
        check("rst gcd16", g16, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_pair(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].max_lat,
                     $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            run_pair(1'b0, ra, rb, ref_gcd(ra, rb), 36, $sformatf("rand%0d", i));
        end

        // Backpressure: result must hold while out_ready is low.
        wide = 1'b0;
        @(negedge clk);
        drv_a = 16'd12;
        drv_b = 16'd8;
        iv8   = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        wait_result(40, cycles, got, busy_seen);
        check("bp out_valid", got, 1);
        check("bp gcd", g, 4);
        for (int i = 0; i < 5; i++) begin
            drv_a = 16'd9;
            drv_b = 16'd3;
            iv8   = 1'b1;
            @(negedge clk);
            check($sformatf("bp hold_valid%0d", i), ov, 1);
            check($sformatf("bp hold_gcd%0d", i), g, 4);
            check($sformatf("bp hold_ready%0d", i), ir, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp idle_valid", ov, 0);
        check("bp idle_ready", ir, 1);
        check("bp gcd_retained", g, 4);
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        wait_result(40, cycles, got, busy_seen);
        check("bp next out_valid", got, 1);
        check("bp next gcd", g, 3);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while the engine is mid-computation.
        @(negedge clk);
        drv_a = 16'd240;
        drv_b = 16'd36;
        iv8   = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst busy_before", busy8, 1);
        rst = 1'b1;
        #1;
        check("midrst out_valid", ov8, 0);
        check("midrst in_ready", ir8, 1);
        check("midrst gcd", g8, 0);
        check("midrst busy", busy8, 0);
        @(negedge clk);
        rst = 1'b0;
        run_pair(1'b0, 16'd240, 16'd36, 16'd12, 36, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
